fifo_rr_merge: RTL and testbench
================================

Name: fifo_rr_merge

Overview:
- N-way round-robin merge of producer streams into a single depth-2 output queue.
- Each beat is tagged with its source index.
- Multi-beat packets are kept contiguous: the grant locks to one source until that source's LAST beat is accepted.
- Sits in front of a shared consumer, so several requesters can share one loopy 2-entry queue resource.

Parameters:
- width, 8, data bits per beat
- nsrc, 4, number of requesters (2..16)
- srcw, 2, source tag width; must satisfy 2**srcw >= nsrc

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, synchronous, active-low
- REQ_DATA  in  nsrc*width  source i data at bits [i*width +: width]
- REQ_VALID  in  nsrc  source i has a beat offered
- REQ_LAST  in  nsrc  source i's offered beat ends its packet
- REQ_ACK  out  nsrc  one-hot; source i's beat is accepted this cycle
- D_OUT  out  width  head data
- D_SRC  out  srcw  head source tag
- D_LAST  out  1  head LAST flag
- EMPTY_N  out  1  head entry valid
- DEQ  in  1  consumer pops head this cycle
- CLR  in  1  synchronous flush

Behaviour:
- Storage: 2 entries of {src, last, data}; count 0..2; entry0 is the head. D_OUT/D_SRC/D_LAST are driven straight from entry0 registers.
- Space (loopy): space = (count<2) || DEQ. Enqueue and dequeue in the same cycle are allowed when full.
- Grant, when unlocked: first i with REQ_VALID[i], scanning ptr, ptr+1, ... mod nsrc.
- Grant, when locked: the lock owner only; no other source is granted even if the owner is idle.
- REQ_ACK[g] = granted && space && !CLR && RST_N. At most one bit is set. The ACK is combinational from VALID, DEQ, ptr, lock state and count.
- Accept (ACK high):
  - Beat is written to entry0 if count==0, or count==1 with DEQ.
  - Otherwise it goes to entry1; when full with DEQ, entry1 shifts to entry0 and the new beat lands in entry1.
  - Tag = g.
- Lock: an accepted beat with LAST=0 sets lock owner = g. An accepted beat with LAST=1 clears the lock and sets ptr = (g+1) mod nsrc.
- ptr changes only on an accepted LAST beat.
- Latency: a beat accepted in cycle t is at the head (EMPTY_N=1) in cycle t+1 if count was 0, or count 1 with DEQ.
- Count update: count +1 on accept without pop; -1 on pop without accept; unchanged on both or neither.
- DEQ with count==0: ignored, no state change. The simulation-only check prints a warning.
- CLR (RST_N high):
  - Next cycle: count=0, lock cleared, ptr=0.
  - REQ_ACK is 0 during the CLR cycle.
  - A DEQ in the same cycle is ignored.
- Reset (RST_N low at a clock edge):
  - count=0 (EMPTY_N=0), lock cleared, ptr=0.
  - REQ_ACK=0 while RST_N is low.
  - Data registers are not reset; D_OUT/D_SRC/D_LAST are don't-care until the first accept.
  - Reset mid-packet abandons the packet; the next grant is purely round-robin from 0.
- Width rules: ptr and the lock owner are srcw bits; modulo wrap is at nsrc, not 2**srcw.
- Sim-only checks:
  - REQ_DATA/REQ_LAST of the lock owner change while VALID is high and ACK is low.
  - nsrc > 2**srcw.

Decomposition:
- Shared package:
  - entry record typedef {src, last, data}
  - round-robin next-pointer function (i+1 mod nsrc)
  - one-hot-to-index function
- Natural sub-module: fifo_rr_merge_buf, the 2-entry loopy tagged buffer, with ENQ/DEQ/CLR/count/space.
- The top holds the arbiter, lock and ptr.

Test Plan:
- Reset, all VALID=0 → EMPTY_N=0, REQ_ACK=0.
- Release reset; VALID=4'b1111, all LAST=1, DEQ held 1 → ACK sequence 0,1,2,3,0; D_SRC follows one cycle later; one beat per cycle.
- Source 2 sends 3 beats with LAST=0,0,1 while source 0 is valid throughout → ACK to 2 for all three beats contiguously, then source 3 if valid, else 0. D_SRC=2 for 3 consecutive heads, D_LAST=1 on the third.
- DEQ=0 with two sources valid → two accepts; count=2, ACK=0. Then DEQ=1 with source 1 valid → ACK same cycle (loopy); count stays 2, head advances.
- CLR asserted mid-packet with source 1 locked and count=2 → next cycle EMPTY_N=0, ptr=0, lock released; source 3 valid alone is then granted.
- DEQ with count 0 → no state change, warning printed. RST_N low for one cycle mid-traffic → same state as the CLR case; no ACK in the reset cycle.

Source files
------------

// File: rtl/fifo_rr_merge_pkg.sv
// Shared types and helpers for the round-robin merge queue.
// The entry record here matches the default 8-bit data / 2-bit tag configuration.
package fifo_rr_merge_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefSrcw  = 2;

  typedef struct packed {
    logic [DefSrcw-1:0]  src;
    logic                last;
    logic [DefWidth-1:0] data;
  } entry_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arbState_t;

  function automatic int unsigned rrNext(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

  // Both operands are below n, so a single conditional subtract is a full modulo.
  function automatic int unsigned rrOffset(input int unsigned base, input int unsigned k,
                                           input int unsigned n);
    return (base + k >= n) ? base + k - n : base + k;
  endfunction

  function automatic int unsigned oneHotToIndex(input logic [15:0] oh);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 15; i >= 0; i--) begin
      if (oh[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rr_merge_buf.sv
// Two-entry tagged queue whose head is a plain register; it accepts a push
// while full as long as the head is popped in the same cycle.
module fifo_rr_merge_buf
  import fifo_rr_merge_pkg::*;
#(
  parameter type entry_t = fifo_rr_merge_pkg::entry_t
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clr_i,
  input  logic       enq_i,
  input  entry_t     enqEntry_i,
  input  logic       deq_i,
  output entry_t     head_o,
  output logic [1:0] count_o,
  output logic       space_o
);

  logic [1:0] count_q, count_d;
  entry_t     entry0_q, entry0_d, entry1_q, entry1_d;
  logic       pop;

  assign pop     = deq_i && (count_q != 2'd0) && !clr_i;
  assign space_o = (count_q != 2'd2) || deq_i;
  assign head_o  = entry0_q;
  assign count_o = count_q;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (clr_i) begin
      count_d = 2'd0;
    end else begin
      if (pop && count_q == 2'd2) entry0_d = entry1_q;
      if (enq_i) begin
        if (count_q == 2'd0 || (count_q == 2'd1 && pop)) entry0_d = enqEntry_i;
        else                                             entry1_d = enqEntry_i;
      end
      count_d = count_q + {1'b0, enq_i} - {1'b0, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  // Payload registers carry no reset; only the occupancy count qualifies them.
  always_ff @(posedge CLK) begin
    entry0_q <= entry0_d;
    entry1_q <= entry1_d;
  end

  always_ff @(posedge CLK) begin
    assert (!(RST_N && !clr_i && deq_i && count_q == 2'd0))
      else $warning("fifo_rr_merge_buf: DEQ on an empty queue is ignored");
  end

endmodule

// File: rtl/fifo_rr_merge.sv
// Round-robin merge of nsrc producer streams into a depth-2 tagged queue.
// A source that starts a multi-beat packet keeps the grant until its LAST beat is taken.
module fifo_rr_merge
  import fifo_rr_merge_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned nsrc  = 4,
  parameter int unsigned srcw  = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [nsrc*width-1:0] REQ_DATA,
  input  logic [nsrc-1:0]       REQ_VALID,
  input  logic [nsrc-1:0]       REQ_LAST,
  output logic [nsrc-1:0]       REQ_ACK,
  output logic [width-1:0]      D_OUT,
  output logic [srcw-1:0]       D_SRC,
  output logic                  D_LAST,
  output logic                  EMPTY_N,
  input  logic                  DEQ,
  input  logic                  CLR
);

  typedef struct packed {
    logic [srcw-1:0]  src;
    logic             last;
    logic [width-1:0] data;
  } localEntry_t;

  arbState_t       state_q, state_d;
  logic [srcw-1:0] ptr_q, ptr_d, owner_q, owner_d;
  logic            grantValid, space, accept;
  logic [srcw-1:0] grantIdx, ackIdx;
  logic [1:0]      count;
  localEntry_t     head, enqEntry;

  // Reverse scan so the candidate closest to ptr is the last (winning) assignment.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    if (state_q == ARB_LOCKED) begin
      grantValid = REQ_VALID[owner_q];
      grantIdx   = owner_q;
    end else begin
      for (int k = int'(nsrc) - 1; k >= 0; k--) begin
        if (REQ_VALID[rrOffset(32'(ptr_q), 32'(k), nsrc)]) begin
          grantValid = 1'b1;
          grantIdx   = srcw'(rrOffset(32'(ptr_q), 32'(k), nsrc));
        end
      end
    end
  end

  always_comb begin
    REQ_ACK = '0;
    if (grantValid && space && !CLR && RST_N) REQ_ACK[grantIdx] = 1'b1;
  end

  assign accept         = |REQ_ACK;
  assign ackIdx         = srcw'(oneHotToIndex(16'(REQ_ACK)));
  assign enqEntry.src   = ackIdx;
  assign enqEntry.last  = REQ_LAST[ackIdx];
  assign enqEntry.data  = REQ_DATA[ackIdx*width +: width];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (accept) begin
      if (enqEntry.last) begin
        state_d = ARB_OPEN;
        ptr_d   = srcw'(rrNext(32'(ackIdx), nsrc));
      end else begin
        state_d = ARB_LOCKED;
        owner_d = ackIdx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      state_q <= ARB_OPEN;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  fifo_rr_merge_buf #(
    .entry_t(localEntry_t)
  ) uBuf (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr_i     (CLR),
    .enq_i     (accept),
    .enqEntry_i(enqEntry),
    .deq_i     (DEQ),
    .head_o    (head),
    .count_o   (count),
    .space_o   (space)
  );

  assign D_OUT   = head.data;
  assign D_SRC   = head.src;
  assign D_LAST  = head.last;
  assign EMPTY_N = (count != 2'd0);

  // A stalled lock owner must keep its offered beat stable until it is taken.
  logic             holdPending_q;
  logic [width-1:0] heldData_q;
  logic             heldLast_q;

  always_ff @(posedge CLK) begin
    holdPending_q <= RST_N && !CLR && (state_q == ARB_LOCKED) &&
                     REQ_VALID[owner_q] && !REQ_ACK[owner_q];
    heldData_q    <= REQ_DATA[owner_q*width +: width];
    heldLast_q    <= REQ_LAST[owner_q];
    if (holdPending_q && state_q == ARB_LOCKED && REQ_VALID[owner_q]) begin
      assert (REQ_DATA[owner_q*width +: width] == heldData_q && REQ_LAST[owner_q] == heldLast_q)
        else $warning("fifo_rr_merge: lock owner changed its beat while stalled");
    end
    assert (nsrc <= (32'd1 << srcw))
      else $error("fifo_rr_merge: srcw is too narrow for nsrc");
  end

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Directed bench for fifo_rr_merge: expected grants are written into each step,
// accepted beats go into a scoreboard queue and are compared as they reach the head.
module tb_fifo_rr_merge;

  localparam int WIDTH = 8;
  localparam int NSRC  = 4;
  localparam int SRCW  = 2;

  logic                  CLK;
  logic                  RST_N;
  logic [NSRC*WIDTH-1:0] REQ_DATA;
  logic [NSRC-1:0]       REQ_VALID;
  logic [NSRC-1:0]       REQ_LAST;
  logic [NSRC-1:0]       REQ_ACK;
  logic [WIDTH-1:0]      D_OUT;
  logic [SRCW-1:0]       D_SRC;
  logic                  D_LAST;
  logic                  EMPTY_N;
  logic                  DEQ;
  logic                  CLR;

  typedef struct {
    logic [SRCW-1:0]  src;
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t      sb[$];
  logic [5:0] seqNo [NSRC];
  int         checks = 0;
  int         errors = 0;

  fifo_rr_merge #(
    .width(WIDTH),
    .nsrc (NSRC),
    .srcw (SRCW)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ_DATA (REQ_DATA),
    .REQ_VALID(REQ_VALID),
    .REQ_LAST (REQ_LAST),
    .REQ_ACK  (REQ_ACK),
    .D_OUT    (D_OUT),
    .D_SRC    (D_SRC),
    .D_LAST   (D_LAST),
    .EMPTY_N  (EMPTY_N),
    .DEQ      (DEQ),
    .CLR      (CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check just after, then retire at posedge.
  task automatic applyStimulus(input logic rstn, input logic [NSRC-1:0] valid,
                               input logic [NSRC-1:0] last, input logic deq, input logic clr,
                               input logic [NSRC-1:0] expAck, input string tag);
    logic [WIDTH-1:0] beatData [NSRC];
    @(negedge CLK);
    RST_N     = rstn;
    REQ_VALID = valid;
    REQ_LAST  = last;
    DEQ       = deq;
    CLR       = clr;
    for (int s = 0; s < NSRC; s++) begin
      beatData[s] = {2'(s), seqNo[s]};
      REQ_DATA[s*WIDTH +: WIDTH] = beatData[s];
    end
    #1;
    checkOutput({tag, " ack"}, 32'(REQ_ACK), 32'(expAck));
    checkOutput({tag, " empty_n"}, 32'(EMPTY_N), (sb.size() != 0) ? 32'd1 : 32'd0);
    if (sb.size() != 0) begin
      checkOutput({tag, " head src"}, 32'(D_SRC), 32'(sb[0].src));
      checkOutput({tag, " head last"}, 32'(D_LAST), 32'(sb[0].last));
      checkOutput({tag, " head data"}, 32'(D_OUT), 32'(sb[0].data));
    end
    @(posedge CLK);
    if (!rstn || clr) begin
      sb.delete();
    end else begin
      if (deq && sb.size() != 0) void'(sb.pop_front());
      for (int s = 0; s < NSRC; s++) begin
        if (expAck[s]) begin
          sb.push_back('{src: 2'(s), last: last[s], data: beatData[s]});
          seqNo[s] = seqNo[s] + 6'd1;
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < NSRC; s++) seqNo[s] = 6'(s * 10);
    RST_N     = 1'b0;
    REQ_VALID = '0;
    REQ_LAST  = '0;
    REQ_DATA  = '0;
    DEQ       = 1'b0;
    CLR       = 1'b0;
    repeat (2) @(posedge CLK);

    // Reset holds the queue empty and suppresses every grant.
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, "reset idle");
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, "reset valid");

    // Single-beat packets from all sources rotate 0,1,2,3,0.
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, "rr0");
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, "rr1");
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, "rr2");
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, "rr3");
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, "rr4");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "rr drain");

    // Three-beat packet from source 2 while source 0 keeps requesting.
    applyStimulus(1'b1, 4'b0101, 4'b0001, 1'b1, 1'b0, 4'b0100, "pkt beat0");
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0000, "pkt owner idle");
    applyStimulus(1'b1, 4'b0101, 4'b0001, 1'b1, 1'b0, 4'b0100, "pkt beat1");
    applyStimulus(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b0, 4'b0100, "pkt beat2");
    applyStimulus(1'b1, 4'b1001, 4'b1001, 1'b1, 1'b0, 4'b1000, "pkt next src3");
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001, "pkt wrap src0");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "pkt drain");

    // Fill without popping, then push through a full queue with a same-cycle pop.
    applyStimulus(1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0010, "fill1");
    applyStimulus(1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0001, "fill2");
    applyStimulus(1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0000, "full stall");
    applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010, "full loopy");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, "full hold");

    // Lock source 1 with the queue full, then flush.
    applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, "lock src1");
    applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0000, "clr cycle");
    applyStimulus(1'b1, 4'b1001, 4'b1001, 1'b1, 1'b0, 4'b0001, "after clr ptr0");
    applyStimulus(1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 4'b1000, "after clr src3");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "clr drain");

    // Popping an empty queue changes nothing.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "deq empty");
    applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, "after deq empty");

    // Reset mid-packet abandons the lock and restarts round robin at 0.
    applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, "lock src2");
    applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, "mid reset");
    applyStimulus(1'b1, 4'b1001, 4'b1001, 1'b0, 1'b0, 4'b0001, "after reset src0");
    applyStimulus(1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 4'b1000, "after reset src3");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "final pop0");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, "final pop1");
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, "final empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
